// File: rtl/crop_stream_ctrl_if.sv
// Single-beat valid/ready stream bundle shared by the raster input and the
// network-facing output of crop_stream_ctrl.
interface crop_stream_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    // Producer side: drives data/valid, observes ready.
    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    // Consumer side: observes data/valid, drives ready.
    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/crop_stream_ctrl.sv
// crop_stream_ctrl: per-frame sequencer for the myproject CNN. Consumes a full
// IN_ROWS x IN_COLS raster, pulses the network's ap_start once, forwards only
// the OUT_ROWS x OUT_COLS window at (y1, x1) through a one-entry output
// register, and reports completion after the network's ap_done and the final
// output drain.
module crop_stream_ctrl #(
    parameter int FP_TOTAL = 16,
    parameter int IN_ROWS  = 100,
    parameter int IN_COLS  = 160,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48,
    parameter int RW       = $clog2(IN_ROWS),
    parameter int CW       = $clog2(IN_COLS),
    parameter int FW       = $clog2(OUT_ROWS*OUT_COLS+1)
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          start,
    input  logic [RW-1:0] cfg_y1,
    input  logic [CW-1:0] cfg_x1,
    crop_stream_if.slave  s,
    crop_stream_if.master m,
    output logic          net_ap_start,
    input  logic          net_ap_done,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err,
    output logic [FW-1:0] fwd_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_y1;
    logic [CW-1:0] r_x1;
    logic [FW-1:0] r_fwd;
    logic          r_done_seen;
    logic          r_cfg_err;
    logic [FP_TOTAL-1:0] r_mdata;
    logic          r_mvalid;

    // One extra bit so y1+OUT_ROWS / x1+OUT_COLS cannot wrap for any cfg value.
    logic [RW:0]   w_y_end_cfg;
    logic [CW:0]   w_x_end_cfg;
    logic [RW:0]   w_y_end;
    logic [CW:0]   w_x_end;
    logic          w_cfg_ok;
    logic          w_start_ok;
    logic          w_cfg_bad;
    logic          w_in_win;
    logic          w_s_tready;
    logic          w_accept;
    logic          w_load;
    logic          w_last_beat;
    logic          w_frame_done;
    logic          w_net_start;

    assign w_y_end_cfg = {1'b0, cfg_y1} + (RW+1)'(OUT_ROWS);
    assign w_x_end_cfg = {1'b0, cfg_x1} + (CW+1)'(OUT_COLS);
    assign w_cfg_ok    = (w_y_end_cfg <= (RW+1)'(IN_ROWS)) &&
                         (w_x_end_cfg <= (CW+1)'(IN_COLS));

    // Window bounds come from the latched cfg, so cfg may change mid-frame.
    assign w_y_end  = {1'b0, r_y1} + (RW+1)'(OUT_ROWS);
    assign w_x_end  = {1'b0, r_x1} + (CW+1)'(OUT_COLS);
    assign w_in_win = (r_row >= r_y1) && ({1'b0, r_row} < w_y_end) &&
                      (r_col >= r_x1) && ({1'b0, r_col} < w_x_end);

    assign w_last_beat = (r_row == RW'(IN_ROWS-1)) && (r_col == CW'(IN_COLS-1));

    assign w_accept = s.tvalid && w_s_tready;
    assign w_load   = w_accept && w_in_win;

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= IDLE;
        else           r_state <= w_state_nx;
    end

    // Next-state and per-state handshake/strobe decode.
    always_comb begin
        w_state_nx   = r_state;
        w_s_tready   = 1'b0;
        w_net_start  = 1'b0;
        w_frame_done = 1'b0;
        w_start_ok   = 1'b0;
        w_cfg_bad    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_start_ok = 1'b1;
                        w_state_nx = START;
                    end else begin
                        w_cfg_bad = 1'b1;
                    end
                end
            end
            START: begin
                w_net_start = 1'b1;
                w_state_nx  = STREAM;
            end
            STREAM: begin
                // Out-of-window pixels are always sunk; window pixels wait for
                // room in the output register (or a same-cycle drain).
                w_s_tready = w_in_win ? (!r_mvalid || m.tready) : 1'b1;
                if (s.tvalid && w_s_tready && w_last_beat)
                    w_state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (r_done_seen && !r_mvalid) begin
                    w_frame_done = 1'b1;
                    w_state_nx   = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Latch crop origin on an accepted start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_y1 <= '0;
            r_x1 <= '0;
        end else if (w_start_ok) begin
            r_y1 <= cfg_y1;
            r_x1 <= cfg_x1;
        end
    end

    // Raster position: advances on every accepted beat, wraps at line end.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_ok) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == CW'(IN_COLS-1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Forwarded-beat count; holds after the frame until the next accepted start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)       r_fwd <= '0;
        else if (w_start_ok) r_fwd <= '0;
        else if (w_load)     r_fwd <= r_fwd + 1'b1;
    end

    // Remember network completion; it may arrive before the raster finishes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_done_seen <= 1'b0;
        else if (w_start_ok)
            r_done_seen <= 1'b0;
        else if (net_ap_done && (r_state == STREAM || r_state == WAIT_DONE))
            r_done_seen <= 1'b1;
    end

    // One-entry output register: load wins over drain, data frozen while stalled.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_mdata  <= '0;
            r_mvalid <= 1'b0;
        end else if (w_load) begin
            r_mdata  <= s.tdata;
            r_mvalid <= 1'b1;
        end else if (m.tready) begin
            r_mvalid <= 1'b0;
        end
    end

    // Registered reject pulse so reset cleanly forces it low.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_cfg_err <= 1'b0;
        else           r_cfg_err <= w_cfg_bad;
    end

    assign s.tready     = w_s_tready;
    assign m.tdata      = r_mdata;
    assign m.tvalid     = r_mvalid;
    assign net_ap_start = w_net_start;
    assign busy         = (r_state != IDLE);
    assign frame_done   = w_frame_done;
    assign cfg_err      = r_cfg_err;
    assign fwd_count    = r_fwd;

endmodule
